div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Sequencing controller between the EX stage and the iterative 32-bit unsigned divider datapath.
//  - Accepts DIV/DIVU requests from EX and handles sign conversion.
//  - Detects divide-by-zero; drives the datapath start level and waits for its done flag.
//  - Applies sign fix-up and returns {HI=remainder, LO=quotient}.
//  - Stalls the pipeline while a divide is in flight, and supports annul (flush) and a watchdog timeout.
// PARAMETERS
//  TIMEOUT   40  max cycles in BUSY waiting for div_done_i before forced abort (must be >=34, <=63)
// PORTS
//  clk           in   1   clock; all logic on rising edge
//  rst           in   1   reset, synchronous, active-high
//  start_i       in   1   EX requests divide; held high until ready_o seen, then dropped
//  annul_i       in   1   flush: cancel pending/in-flight divide
//  signed_i      in   1   1=DIV (two's complement), 0=DIVU
//  opdata1_i     in   32  dividend
//  opdata2_i     in   32  divisor
//  div_start_o   out  1   level to datapath; high for the whole BUSY state, low elsewhere
//  div_a_o       out  32  unsigned dividend magnitude to datapath (registered)
//  div_b_o       out  32  unsigned divisor magnitude to datapath (registered)
//  div_done_i    in   1   datapath finished
//  div_quot_i    in   32  datapath unsigned quotient
//  div_rem_i     in   32  datapath unsigned remainder
//  result_o      out  64  {remainder,quotient} after sign fix-up; valid while ready_o=1
//  ready_o       out  1   result valid
//  stall_o       out  1   stall request to pipeline control
//  timeout_o     out  1   one-cycle pulse when watchdog fires
// BEHAVIOUR
//  Reset: state=IDLE, div_start_o=0, div_a_o=div_b_o=0, result_o=0, ready_o=0, timeout_o=0, counter=0.
//  States: IDLE, DIVZERO, BUSY, DONE (registered FSM). annul_i in any state -> IDLE next cycle; highest priority after rst.
//  IDLE: on start_i&!annul_i:
//   - if opdata2_i==0 -> DIVZERO;
//   - else latch div_a_o=|op1|, div_b_o=|op2| (abs only if signed_i), latch neg_q=signed_i&(op1[31]^op2[31]), neg_r=signed_i&op1[31];
//     clear counter -> BUSY.
//  DIVZERO: result_o=64'h0 -> DONE (one cycle).
//  BUSY: div_start_o=1; counter increments each cycle.
//   - div_done_i=1 -> capture result_o: quot=neg_q?-div_quot_i:div_quot_i, rem=neg_r?-div_rem_i:div_rem_i -> DONE.
//   - counter==TIMEOUT-1 without done -> result_o=0, timeout_o pulse -> DONE.
//   - done and timeout in same cycle: done wins, no timeout_o.
//  DONE: ready_o=1, div_start_o=0; stays while start_i=1; start_i=0 -> IDLE, ready_o=0, result_o held.
//  stall_o = (IDLE&start_i&!annul_i) | DIVZERO | BUSY; combinational; 0 in DONE.
//  Latency: request-to-ready = datapath latency + 2 cycles; divide-by-zero = 2 cycles.
//  Arithmetic:
//   - negation is 32-bit two's complement, wrap allowed: 0x80000000/-1 signed -> quot 0x80000000, rem 0.
//   - -0 stays 0.
//  Sign rules: remainder takes sign of dividend; quotient truncates toward zero.
//  Operands/signed_i sampled only in IDLE; later changes ignored until next request.
//  rst mid-BUSY: back to IDLE next edge, div_start_o drops, no ready_o.
//  New request needs start_i low for >=1 cycle after ready_o (no back-to-back without gap).
// TESTING
//  1. DIVU 100/7 -> after done, ready_o=1, result_o={32'd2,32'd14}; stall_o high until ready.
//  2. DIV -7/2 (0xFFFFFFF9,2) -> quot 0xFFFFFFFD, rem 0xFFFFFFFF; DIV 7/-2 -> quot 0xFFFFFFFD, rem 1.
//  3. DIV/DIVU x/0 -> no div_start_o, ready_o two cycles after request, result_o=0, timeout_o=0.
//  4. DIV 0x80000000/0xFFFFFFFF -> result_o={32'h0,32'h80000000}.
//  5. annul_i 10 cycles into BUSY -> IDLE next cycle, div_start_o=0, no ready_o; next request 9/3 -> quot 3, rem 0.
//  6. div_done_i tied 0 -> timeout_o pulse at TIMEOUT cycles in BUSY, ready_o=1, result_o=0; rst mid-BUSY -> all outputs at reset values.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//   Sequencing controller between the EX stage and an iterative 32-bit
//   unsigned divider datapath. It converts signed operands to magnitudes,
//   short-circuits divide-by-zero, holds the datapath start level while the
//   divide runs, applies the sign fix-up to the returned quotient/remainder
//   and stalls the pipeline until the result is ready. A flush (annul_i)
//   cancels at any point, and a watchdog aborts a datapath that never finishes.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start_i             divide request, held until ready_o is seen
//   annul_i             flush: cancel pending/in-flight divide
//   signed_i            1 = DIV (two's complement), 0 = DIVU
//   opdata1_i/2_i       dividend / divisor
//   div_start_o         level to datapath, high for the whole BUSY state
//   div_a_o/div_b_o     registered unsigned magnitudes to datapath
//   div_done_i          datapath finished
//   div_quot_i/rem_i    datapath unsigned quotient / remainder
//   result_o            {remainder, quotient} after sign fix-up
//   ready_o             result valid (DONE state)
//   stall_o             stall request to pipeline control
//   timeout_o           one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  // Cycles allowed in BUSY before a forced abort; must lie in [34, 63] so a
  // healthy 32-iteration datapath always finishes and the 6-bit counter fits.
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic        div_start_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic        div_done_i,
  input  logic [31:0] div_quot_i,
  input  logic [31:0] div_rem_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_BUSY    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic        neg_q_q;      // quotient must be negated
  logic        neg_r_q;      // remainder must be negated
  logic        timeout_hit;
  logic [31:0] abs_a, abs_b;
  logic [31:0] fix_quot, fix_rem;

  assign timeout_hit = (cnt_q == 6'(TIMEOUT - 1));

  // Magnitudes: two's complement negation wraps, so 0x80000000 stays
  // 0x80000000 (the datapath treats it as unsigned 2^31) and -0 stays 0.
  assign abs_a = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign abs_b = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

  // Quotient truncates toward zero, remainder follows the dividend's sign.
  assign fix_quot = neg_q_q ? -div_quot_i : div_quot_i;
  assign fix_rem  = neg_r_q ? -div_rem_i  : div_rem_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    div_start_o = 1'b0;
    ready_o     = 1'b0;
    stall_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          stall_o = 1'b1;
          state_d = (opdata2_i == 32'd0) ? S_DIVZERO : S_BUSY;
        end
      end
      S_DIVZERO: begin
        stall_o = 1'b1;
        state_d = S_DONE;
      end
      S_BUSY: begin
        div_start_o = 1'b1;
        stall_o     = 1'b1;
        if (div_done_i || timeout_hit) state_d = S_DONE;
      end
      S_DONE: begin
        ready_o = 1'b1;
        if (!start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush overrides every transition above.
    if (annul_i) state_d = S_IDLE;
  end

  // Operand, sign, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_a_o   <= 32'd0;
      div_b_o   <= 32'd0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      cnt_q     <= 6'd0;
      result_o  <= 64'd0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if (!annul_i) begin
        case (state_q)
          S_IDLE: begin
            // Operands are captured only here; later changes are ignored.
            if (start_i && (opdata2_i != 32'd0)) begin
              div_a_o <= abs_a;
              div_b_o <= abs_b;
              neg_q_q <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_r_q <= signed_i & opdata1_i[31];
              cnt_q   <= 6'd0;
            end
          end
          S_DIVZERO: result_o <= 64'd0;
          S_BUSY: begin
            cnt_q <= cnt_q + 6'd1;
            // done wins over a coincident watchdog expiry
            if (div_done_i) begin
              result_o <= {fix_rem, fix_quot};
            end else if (timeout_hit) begin
              result_o  <= 64'd0;
              timeout_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
//   Directed bench for div_seq_ctrl. A small behavioural datapath answers
//   div_start_o after DP_LAT cycles (or never, when dp_en is low). Expected
//   results come from a 64-bit reference division and are pushed to a
//   scoreboard queue when each request is driven, then popped at ready_o.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

  localparam int TIMEOUT = 40;
  localparam int DP_LAT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        div_start_o;
  logic [31:0] div_a_o, div_b_o;
  logic        div_done_i = 1'b0;
  logic [31:0] div_quot_i = 32'd0;
  logic [31:0] div_rem_i = 32'd0;
  logic [63:0] result_o;
  logic        ready_o, stall_o, timeout_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] sb_q[$];

  logic        dp_en = 1'b1;
  int          dp_cnt = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .div_start_o(div_start_o),
    .div_a_o    (div_a_o),
    .div_b_o    (div_b_o),
    .div_done_i (div_done_i),
    .div_quot_i (div_quot_i),
    .div_rem_i  (div_rem_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_o    (stall_o),
    .timeout_o  (timeout_o)
  );

  // Behavioural unsigned datapath: pulses done DP_LAT cycles after start rises.
  always @(posedge clk) begin
    if (!div_start_o) begin
      dp_cnt     <= 0;
      div_done_i <= 1'b0;
    end else begin
      dp_cnt <= dp_cnt + 1;
      if (dp_en && dp_cnt == DP_LAT - 1 && div_b_o != 32'd0) begin
        div_done_i <= 1'b1;
        div_quot_i <= div_a_o / div_b_o;
        div_rem_i  <= div_a_o % div_b_o;
      end else begin
        div_done_i <= 1'b0;
      end
    end
  end

  // Reference {rem, quot}: 64-bit arithmetic avoids the 0x80000000/-1 overflow.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response handshake with latency, stall and hold checks.
  task automatic do_req(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic exp_to);
    logic [63:0] exp_res;
    int          cyc;
    int          exp_lat;
    logic        saw_start;
    logic        stall_gap;

    exp_lat = (b == 32'd0) ? 2 : (exp_to ? TIMEOUT + 1 : DP_LAT + 2);
    sb_q.push_back(exp_to ? 64'd0 : ref_div(sgn, a, b));

    @(negedge clk);
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    #1;
    check({tag, " stall@req"}, 64'(stall_o), 64'd1);

    cyc       = 0;
    saw_start = 1'b0;
    stall_gap = 1'b0;
    while (!ready_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (b != 32'd0) begin
          check({tag, " div_a"}, 64'(div_a_o), 64'(mag(sgn, a)));
          check({tag, " div_b"}, 64'(div_b_o), 64'(mag(sgn, b)));
        end
        // Scramble operands: the latched request must be unaffected.
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
      end
      if (div_start_o) saw_start = 1'b1;
      if (!ready_o && !stall_o) stall_gap = 1'b1;
    end

    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " ready"}, 64'(ready_o), 64'd1);
    check({tag, " div_start used"}, 64'(saw_start), 64'(b != 32'd0));
    check({tag, " stall held"}, 64'(stall_gap), 64'd0);
    check({tag, " stall in done"}, 64'(stall_o), 64'd0);
    exp_res = sb_q.pop_front();
    check({tag, " result"}, result_o, exp_res);
    check({tag, " timeout"}, 64'(timeout_o), 64'(exp_to));

    @(negedge clk);
    check({tag, " ready hold"}, 64'(ready_o), 64'd1);
    check({tag, " timeout pulse"}, 64'(timeout_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    check({tag, " ready drop"}, 64'(ready_o), 64'd0);
    check({tag, " result held"}, result_o, exp_res);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst div_start", 64'(div_start_o), 64'd0);
    check("rst div_a", 64'(div_a_o), 64'd0);
    check("rst result", result_o, 64'd0);
    check("rst ready", 64'(ready_o), 64'd0);
    check("rst stall", 64'(stall_o), 64'd0);
    check("rst timeout", 64'(timeout_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Main function and arithmetic corner cases.
    do_req("divu 100/7", 1'b0, 32'd100, 32'd7, 1'b0);
    do_req("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_req("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_req("div x/0", 1'b1, 32'd1234, 32'd0, 1'b0);
    do_req("divu x/0", 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_req("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_req("divu max/3", 1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0);
    do_req("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
    do_req("div 0/-5", 1'b1, 32'd0, 32'hFFFF_FFFB, 1'b0);

    // Annul ten cycles into BUSY.
    dp_en = 1'b0;
    @(negedge clk);
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (11) @(negedge clk);
    check("annul busy", 64'(div_start_o), 64'd1);
    annul_i = 1'b1;
    @(negedge clk);
    check("annul div_start", 64'(div_start_o), 64'd0);
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul stall", 64'(stall_o), 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("annul no ready", 64'(ready_o), 64'd0);
    dp_en = 1'b1;
    do_req("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 1'b0);

    // Watchdog: datapath never answers.
    dp_en = 1'b0;
    do_req("timeout", 1'b0, 32'd50, 32'd5, 1'b1);

    // Reset in the middle of BUSY.
    @(negedge clk);
    signed_i  = 1'b1;
    opdata1_i = 32'hFFFF_FF00;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (5) @(negedge clk);
    check("rst-busy div_start before", 64'(div_start_o), 64'd1);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("rst-busy div_start", 64'(div_start_o), 64'd0);
    check("rst-busy div_a", 64'(div_a_o), 64'd0);
    check("rst-busy div_b", 64'(div_b_o), 64'd0);
    check("rst-busy result", result_o, 64'd0);
    check("rst-busy ready", 64'(ready_o), 64'd0);
    check("rst-busy stall", 64'(stall_o), 64'd0);
    check("rst-busy timeout", 64'(timeout_o), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst-busy no ready", 64'(ready_o), 64'd0);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
